// File: rtl/flush_ctrl_pkg.sv
// Shared types and constants for the flush controller and its fetch tracker.
package flush_ctrl_pkg;

    // Number of pipeline stage-kill lines driven on a flush.
    localparam int FLUSH_WD = 4;

    // General exception vector; eret targets come from EPC instead.
    localparam logic [31:0] EXC_VECTOR = 32'hbfc00380;

    // Flush sequencing: wait for data-side drain, then offer the redirect to IF.
    typedef enum logic [1:0] {
        FC_IDLE     = 2'd0,
        FC_DRAIN    = 2'd1,
        FC_REDIRECT = 2'd2
    } fc_state_t;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/flush_ctrl_fetch_tracker.sv
// Tracks outstanding instruction-fetch requests and marks responses that
// belong to a squashed stream so IF can drop them on arrival.
module flush_ctrl_fetch_tracker
    import flush_ctrl_pkg::*;
#(
    parameter int MAX_OUTST = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush_accept,
    input  logic if_req_fire_i,
    input  logic if_data_ok_i,
    output logic discard_o
);

    // The discard count can exceed MAX_OUTST by one: a fetch accepted in the
    // flush cycle while already at the limit is still part of the old stream.
    localparam int OW = cnt_width(MAX_OUTST);
    localparam int DW = cnt_width(MAX_OUTST + 1);

    logic [OW-1:0] outst_reg, outst_next;
    logic [DW-1:0] discard_reg, discard_next;
    logic [DW-1:0] discard_load;

    // Outstanding-request counter: up on accept, down on response, saturating.
    always_comb begin
        outst_next = outst_reg;
        if (if_req_fire_i && !if_data_ok_i) begin
            if (outst_reg != OW'(MAX_OUTST)) begin
                outst_next = outst_reg + OW'(1);
            end
        end else if (!if_req_fire_i && if_data_ok_i) begin
            if (outst_reg != '0) begin
                outst_next = outst_reg - OW'(1);
            end
        end
    end

    // Stale-response count captured at flush time: everything still in flight
    // plus a request accepted this cycle, minus a response already killed now.
    always_comb begin
        discard_load = DW'(outst_reg);
        if (if_req_fire_i && !if_data_ok_i) begin
            discard_load = DW'(outst_reg) + DW'(1);
        end else if (!if_req_fire_i && if_data_ok_i && (outst_reg != '0)) begin
            discard_load = DW'(outst_reg) - DW'(1);
        end
    end

    // Discard counter: load on flush, otherwise consume one per response.
    always_comb begin
        discard_next = discard_reg;
        if (flush_accept) begin
            discard_next = discard_load;
        end else if (if_data_ok_i && (discard_reg != '0)) begin
            discard_next = discard_reg - DW'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            outst_reg   <= '0;
            discard_reg <= '0;
        end else begin
            outst_reg   <= outst_next;
            discard_reg <= discard_next;
        end
    end

    // Responses return in order, so any response while the count is nonzero is stale.
    assign discard_o = if_data_ok_i && (discard_reg != '0);

endmodule

// File: rtl/flush_ctrl.sv
// Exception/eret flush controller: kills pipeline stages, stalls fetch until
// data-side traffic drains, then hands the redirect PC to IF.
module flush_ctrl
    import flush_ctrl_pkg::*;
#(
    parameter int MAX_OUTST = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_req_i,
    input  logic [31:0]         flush_pc_i,
    input  logic                caused_by_i1_i,
    input  logic                mem_wait_i,
    input  logic                if_req_fire_i,
    input  logic                if_data_ok_i,
    output logic [FLUSH_WD-1:0] flush_o,
    output logic [1:0]          wb_kill_o,
    output logic                if_stall_o,
    output logic                redirect_valid_o,
    output logic [31:0]         redirect_pc_o,
    input  logic                redirect_ready_i,
    output logic                discard_o
);

    fc_state_t   state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        flush_accept;

    // A request outside IDLE arrives after the pipeline was already emptied.
    assign flush_accept = flush_req_i && (state_reg == FC_IDLE);

    // State and captured redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FC_IDLE;
            pc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    // Next-state and front-end control.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        if_stall_o       = 1'b0;
        redirect_valid_o = 1'b0;
        case (state_reg)
            FC_IDLE: begin
                if (flush_req_i) begin
                    pc_next    = flush_pc_i;
                    state_next = mem_wait_i ? FC_DRAIN : FC_REDIRECT;
                end
            end
            FC_DRAIN: begin
                if_stall_o = 1'b1;
                if (!mem_wait_i) begin
                    state_next = FC_REDIRECT;
                end
            end
            FC_REDIRECT: begin
                if_stall_o       = 1'b1;
                redirect_valid_o = 1'b1;
                if (redirect_ready_i) begin
                    state_next = FC_IDLE;
                end
            end
            default: begin
                state_next = FC_IDLE;
            end
        endcase
    end

    // Every stage register is killed in the accepting cycle.
    generate
        for (genvar gi = 0; gi < FLUSH_WD; gi++) begin : g_kill
            assign flush_o[gi] = flush_accept;
        end
    endgenerate

    // Lane2 never retires on a flush; lane1 retires when only lane2 faulted.
    assign wb_kill_o     = flush_accept ? {1'b1, caused_by_i1_i} : 2'b00;
    assign redirect_pc_o = pc_reg;

    flush_ctrl_fetch_tracker #(
        .MAX_OUTST (MAX_OUTST)
    ) u_fetch_tracker (
        .clk           (clk),
        .rst           (rst),
        .flush_accept  (flush_accept),
        .if_req_fire_i (if_req_fire_i),
        .if_data_ok_i  (if_data_ok_i),
        .discard_o     (discard_o)
    );

endmodule
